ped_signal_ctrl: RTL and testbench
==================================

PED_SIGNAL_CTRL -- requirements
Module: ped_signal_ctrl

Interface
REQ-001 Parameter WALK_TIME, default 6, walk phase length in clk cycles (1..12).
REQ-002 Parameter FLASH_TIME, default 3, flashing don't-walk length in clk cycles (1..3); WALK_TIME+FLASH_TIME SHALL be <= 15.
REQ-003 Parameter PED_RECALL, default 0, 1 = serve a crossing on every red phase without a button request.
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 redlight  input  1  vehicle red from traffic light controller, synchronous to clk.
REQ-007 oralight  input  1  vehicle orange, synchronous to clk.
REQ-008 grelight  input  1  vehicle green, synchronous to clk.
REQ-009 ped_btn  input  1  pedestrian push button, asynchronous, active-high.
REQ-010 walk  output  1  walk lamp.
REQ-011 dont_walk  output  1  don't-walk lamp (steady or flashing).
REQ-012 countdown  output  4  remaining crossing cycles, 0 when not crossing.
REQ-013 req_pending  output  1  latched pedestrian request awaiting service.
REQ-014 fault  output  1  sticky illegal-lamp-combination flag.

Function
REQ-015 ped_btn SHALL pass a 2-flop synchronizer; a rising edge of the synchronized value is one press.
REQ-016 A press SHALL set req_pending in the following cycle; further presses while set have no effect.
REQ-017 A red rising edge SHALL be detected against a registered copy of redlight (red=1, previous=0).
REQ-018 States: IDLE, WALK, FLASH, FAULT.
REQ-019 IDLE -> WALK on red rising edge when req_pending=1, or PED_RECALL=1, or a press is detected in the same cycle.
REQ-020 On WALK entry countdown SHALL load WALK_TIME+FLASH_TIME and req_pending SHALL clear; a press on the entry cycle is consumed by it.
REQ-021 countdown SHALL decrement by 1 every cycle in WALK and FLASH.
REQ-022 WALK -> FLASH when countdown = FLASH_TIME+1 and decrementing; FLASH -> IDLE when countdown reaches 0.
REQ-023 WALK: walk=1, dont_walk=0; FLASH: walk=0, dont_walk=1 on first FLASH cycle, toggling every cycle; IDLE: walk=0, dont_walk=1, countdown=0.
REQ-024 Presses during WALK or FLASH SHALL set req_pending for the next red phase.
REQ-025 redlight falling while in WALK or FLASH SHALL force IDLE next cycle, countdown=0, dont_walk=1 (safety abort); req_pending unaffected.
REQ-026 walk and dont_walk SHALL never both be 1.

Reset
REQ-027 While rst_n=0: state IDLE, walk=0, dont_walk=1, countdown=0, req_pending=0, fault=0, synchronizer and red history flops cleared.
REQ-028 Reset assertion mid-crossing SHALL abort immediately (asynchronous); first post-reset red edge requires a fresh request unless PED_RECALL=1.

Configuration
REQ-029 Macro PED_FAULT_CHECK_EN: when defined, any cycle with more than one of redlight/oralight/grelight high SHALL set fault and enter FAULT (walk=0, dont_walk=1, countdown=0) until reset.
REQ-030 Without PED_FAULT_CHECK_EN: fault tied 0, FAULT state unreachable, lamp combinations unchecked.

Structure
REQ-031 Package ped_pkg SHALL hold the state enum and default WALK_TIME/FLASH_TIME/countdown width constants.
REQ-032 Sub-module ped_btn_sync SHALL implement synchronizer plus rising-edge detect; FSM and counter stay in ped_signal_ctrl.

Verification
REQ-033 Press ped_btn, then red rises -> req_pending=1 before red; walk=1 for 6 cycles with countdown 9..4, FLASH 3 cycles countdown 3..1 with dont_walk 1,0,1, then IDLE countdown=0.
REQ-034 Red rises with no press, PED_RECALL=0 -> stays IDLE, walk never 1; repeat with PED_RECALL=1 -> crossing served.
REQ-035 Red falls at countdown=6 -> next cycle walk=0, dont_walk=1, countdown=0, state IDLE.
REQ-036 Press during WALK -> req_pending=1 after crossing; next red edge starts new crossing and clears it.
REQ-037 rst_n low at countdown=5 -> outputs at reset values immediately, without waiting for clk.
REQ-038 With PED_FAULT_CHECK_EN, redlight=grelight=1 for one cycle -> fault=1, dont_walk=1, stays until rst_n low; without macro fault stays 0.

Source files
------------

// File: rtl/ped_pkg.sv
// rtl/ped_pkg.sv - shared types and defaults for the pedestrian signal controller
//
// Purpose : state encoding and default timing constants used by ped_signal_ctrl.
// Contents: ped_state_e     - controller states (IDLE, WALK, FLASH, FAULT)
//           DEF_WALK_TIME   - default walk phase length in clk cycles
//           DEF_FLASH_TIME  - default flashing don't-walk length in clk cycles
//           CNT_W           - countdown width in bits
package ped_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WALK  = 2'd1,
    ST_FLASH = 2'd2,
    ST_FAULT = 2'd3
  } ped_state_e;

  localparam int DEF_WALK_TIME  = 6;
  localparam int DEF_FLASH_TIME = 3;
  localparam int CNT_W          = 4;

endpackage

// File: rtl/ped_btn_sync.sv
// rtl/ped_btn_sync.sv - push-button synchronizer with rising-edge detect
//
// Purpose : brings the asynchronous pedestrian button into the clk domain
//           through two flops and reports a one-cycle pulse per press.
// Ports   : clk   - clock, rising edge
//           rst_n - asynchronous active-low reset
//           btn   - raw push button, asynchronous, active-high
//           press - one-cycle pulse on a rising edge of the synchronized button
module ped_btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign press = sync2_q & ~prev_q;

endmodule

// File: rtl/ped_signal_ctrl.sv
// rtl/ped_signal_ctrl.sv - pedestrian crossing lamp controller slaved to the vehicle lights
//
// Purpose : serves a crossing (walk, then flashing don't-walk) at the start of
//           each vehicle red phase when a request is pending or recall is on.
// Ports   : clk, rst_n          - clock (rising edge), asynchronous active-low reset
//           redlight/oralight/grelight - vehicle lamps, synchronous to clk
//           ped_btn            - pedestrian button, asynchronous
//           walk, dont_walk    - pedestrian lamps
//           countdown          - remaining crossing cycles, 0 when not crossing
//           req_pending        - latched request awaiting the next red phase
//           fault              - sticky illegal vehicle lamp combination flag
// Config  : define PED_FAULT_CHECK_EN to enable the lamp-combination check and
//           FAULT state; otherwise fault is tied low.
module ped_signal_ctrl
  import ped_pkg::*;
#(
  parameter int WALK_TIME  = DEF_WALK_TIME,
  parameter int FLASH_TIME = DEF_FLASH_TIME,
  parameter int PED_RECALL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             redlight,
  input  logic             oralight,
  input  logic             grelight,
  input  logic             ped_btn,
  output logic             walk,
  output logic             dont_walk,
  output logic [CNT_W-1:0] countdown,
  output logic             req_pending,
  output logic             fault
);

  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(WALK_TIME + FLASH_TIME);
  localparam logic [CNT_W-1:0] WALK_LAST  = CNT_W'(FLASH_TIME + 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  ped_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             req_q;
  logic             flash_q;
  logic             red_q;
  logic             press;
  logic             red_rise, red_fall;
  logic             start;

  ped_btn_sync u_btn_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (ped_btn),
    .press(press)
  );

  assign red_rise = redlight & ~red_q;
  assign red_fall = ~redlight & red_q;
  assign start    = (state_q == ST_IDLE) && (state_d == ST_WALK);

`ifdef PED_FAULT_CHECK_EN
  logic lamp_conflict;
  logic fault_q;

  assign lamp_conflict = (redlight & oralight) | (redlight & grelight) | (oralight & grelight);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else if (lamp_conflict) fault_q <= 1'b1;
  end

  assign fault = fault_q;
`else
  logic lamp_unused;
  assign lamp_unused = oralight ^ grelight;
  assign fault       = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a red falling edge aborts any crossing in progress
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (red_rise && (req_q || (PED_RECALL != 0) || press)) state_d = ST_WALK;
      ST_WALK:  if (red_fall) state_d = ST_IDLE;
                else if (cnt_q == WALK_LAST) state_d = ST_FLASH;
      ST_FLASH: if (red_fall || (cnt_q == CNT_ONE)) state_d = ST_IDLE;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
`ifdef PED_FAULT_CHECK_EN
    if (lamp_conflict) state_d = ST_FAULT;
`endif
  end

  // Output decode
  always_comb begin
    walk      = 1'b0;
    dont_walk = 1'b1;
    case (state_q)
      ST_WALK:  begin walk = 1'b1; dont_walk = 1'b0; end
      ST_FLASH: dont_walk = flash_q;
      default:  ;
    endcase
  end

  assign countdown   = cnt_q;
  assign req_pending = req_q;

  // Countdown, flash phase and request latch follow the next state so they
  // line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      req_q   <= 1'b0;
      flash_q <= 1'b1;
      red_q   <= 1'b0;
    end else begin
      red_q <= redlight;

      if (start)
        cnt_q <= CNT_LOAD;
      else if ((state_d == ST_WALK) || (state_d == ST_FLASH))
        cnt_q <= cnt_q - CNT_ONE;
      else
        cnt_q <= '0;

      // Flash starts lit and toggles every cycle while flashing
      if ((state_d == ST_FLASH) && (state_q == ST_FLASH)) flash_q <= ~flash_q;
      else                                                flash_q <= 1'b1;

      // A press on the entry cycle is consumed by the crossing it starts
      if (start)      req_q <= 1'b0;
      else if (press) req_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ped_signal_ctrl.sv
// tb/tb_ped_signal_ctrl.sv - self-checking bench for ped_signal_ctrl
module tb_ped_signal_ctrl;

  logic       clk;
  logic       rst_n;
  logic       redlight, oralight, grelight, ped_btn;
  logic       walk, dont_walk, req_pending, fault;
  logic [3:0] countdown;
  logic       walk_rc, dont_walk_rc, req_rc, fault_rc;
  logic [3:0] cnt_rc;

  int tests  = 0;
  int failed = 0;
  int overlap_err = 0;
  int exp_fault;

  ped_signal_ctrl dut (
    .clk(clk), .rst_n(rst_n), .redlight(redlight), .oralight(oralight),
    .grelight(grelight), .ped_btn(ped_btn), .walk(walk), .dont_walk(dont_walk),
    .countdown(countdown), .req_pending(req_pending), .fault(fault)
  );

  ped_signal_ctrl #(.PED_RECALL(1)) dut_rc (
    .clk(clk), .rst_n(rst_n), .redlight(redlight), .oralight(oralight),
    .grelight(grelight), .ped_btn(ped_btn), .walk(walk_rc), .dont_walk(dont_walk_rc),
    .countdown(cnt_rc), .req_pending(req_rc), .fault(fault_rc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if ((walk && dont_walk) || (walk_rc && dont_walk_rc)) overlap_err++;
  end

  typedef struct packed {
    logic       red;
    logic       btn;
    logic       walk;
    logic       dw;
    logic [3:0] cnt;
    logic       req;
  } vec_t;

  vec_t tbl [14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
`ifdef PED_FAULT_CHECK_EN
    exp_fault = 1;
`else
    exp_fault = 0;
`endif
    //            red   btn   walk  dw    cnt    req
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd9, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd8, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd7, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd6, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd5, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd4, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0};

    rst_n = 1'b1; redlight = 1'b0; oralight = 1'b0; grelight = 1'b0; ped_btn = 1'b0;
    #2 rst_n = 1'b0;
    step(); step();
    chk("rst_walk", walk, 0);
    chk("rst_dont_walk", dont_walk, 1);
    chk("rst_countdown", countdown, 0);
    chk("rst_req", req_pending, 0);
    chk("rst_fault", fault, 0);
    rst_n = 1'b1;
    step();

    // Basic crossing after a press
    for (int i = 0; i < 14; i++) begin
      redlight = tbl[i].red;
      ped_btn  = tbl[i].btn;
      step();
      chk($sformatf("vec%0d_walk", i), walk, tbl[i].walk);
      chk($sformatf("vec%0d_dw", i), dont_walk, tbl[i].dw);
      chk($sformatf("vec%0d_cnt", i), countdown, tbl[i].cnt);
      chk($sformatf("vec%0d_req", i), req_pending, tbl[i].req);
    end

    // Red without request: only the recall instance crosses
    redlight = 1'b1;
    step();
    chk("norq_walk", walk, 0);
    chk("norq_cnt", countdown, 0);
    chk("recall_walk", walk_rc, 1);
    chk("recall_cnt", cnt_rc, 9);
    for (int i = 0; i < 11; i++) begin
      step();
      chk("norq_walk_hold", walk, 0);
    end
    redlight = 1'b0;
    step();

    // Safety abort at countdown 6 with a press made during walk
    ped_btn = 1'b1; step(); step();
    ped_btn = 1'b0; step();
    redlight = 1'b1; step();
    chk("abort_start_cnt", countdown, 9);
    ped_btn = 1'b1; step(); step();
    ped_btn = 1'b0; step();
    chk("abort_pre_cnt", countdown, 6);
    chk("abort_pre_req", req_pending, 1);
    redlight = 1'b0; step();
    chk("abort_walk", walk, 0);
    chk("abort_dw", dont_walk, 1);
    chk("abort_cnt", countdown, 0);
    chk("abort_req", req_pending, 1);

    // Pending request serves next red; press during walk carries over
    redlight = 1'b1; step();
    chk("srv_walk", walk, 1);
    chk("srv_cnt", countdown, 9);
    chk("srv_req", req_pending, 0);
    ped_btn = 1'b1; step(); step();
    ped_btn = 1'b0; step();
    for (int k = 0; k < 20 && countdown != 0; k++) step();
    chk("carry_cnt", countdown, 0);
    chk("carry_walk", walk, 0);
    chk("carry_req", req_pending, 1);
    redlight = 1'b0; step();
    redlight = 1'b1; step();
    chk("carry_srv_walk", walk, 1);
    chk("carry_srv_req", req_pending, 0);

    // Asynchronous reset mid-crossing at countdown 5
    ped_btn = 1'b1; step(); step();
    ped_btn = 1'b0; step(); step();
    chk("ar_pre_cnt", countdown, 5);
    chk("ar_pre_req", req_pending, 1);
    #2 rst_n = 1'b0;
    redlight = 1'b0;
    #1;
    chk("ar_walk", walk, 0);
    chk("ar_dw", dont_walk, 1);
    chk("ar_cnt", countdown, 0);
    chk("ar_req", req_pending, 0);
    step(); step();
    rst_n = 1'b1;
    step();
    redlight = 1'b1; step();
    chk("post_rst_walk", walk, 0);
    chk("post_rst_recall_walk", walk_rc, 1);
    redlight = 1'b0; step();

    // Illegal lamp combination
    redlight = 1'b1; grelight = 1'b1; step();
    grelight = 1'b0; step();
    chk("fault_set", fault, exp_fault);
    chk("fault_dw", dont_walk, 1);
    chk("fault_walk", walk, 0);
    step(); step(); step();
    chk("fault_hold", fault, exp_fault);
    chk("fault_hold_cnt", countdown, 0);
    rst_n = 1'b0; #1;
    chk("fault_clr", fault, 0);
    step();
    rst_n = 1'b1; redlight = 1'b0;
    step();

    chk("lamp_overlap", overlap_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
